// File: rtl/data_sram_bridge.sv
// data_sram_bridge: converts the M-stage load/store into a single SRAM-like
// data bus transaction (req/addr_ok/data_ok) and stalls the pipeline until
// the data phase completes. At most one transaction is in flight.
// Optional: define DSRAM_BRIDGE_PERF_EN to add saturating performance counters.
module data_sram_bridge #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int KSEG_MAP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W/8-1:0] readEnM,
    input  logic [DATA_W/8-1:0] writeEnM,
    input  logic [ADDR_W-1:0]   aluoutM,
    input  logic [DATA_W-1:0]   writedata_decodedM,
    input  logic [1:0]          size,
    input  logic [31:0]         exceptTypeM,
    input  logic                flush_except,
    input  logic                stallM,
    output logic [DATA_W-1:0]   readdataM,
    output logic                stallreq_from_mem,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    input  logic                data_data_ok
`ifdef DSRAM_BRIDGE_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_accesses
`endif
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    state_e            state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;

    bus_req_t new_req;
    bus_req_t bus_cur;
    logic     acc;
    logic     req_c;
    logic     stall_c;

    // kseg0/kseg1 are unmapped windows onto the low 512MB of physical space
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] va);
        logic [ADDR_W-1:0] pa;
        pa = va;
        if ((KSEG_MAP != 0) && (va[ADDR_W-1 -: 2] == 2'b10))
            pa[ADDR_W-1 -: 3] = 3'b000;
        return pa;
    endfunction

    // Decode the M-stage access into a bus request; stores win over loads
    always_comb begin
        acc           = ((|readEnM) | (|writeEnM)) & (exceptTypeM == 32'd0) & ~flush_except;
        new_req.wr    = |writeEnM;
        new_req.size  = size;
        new_req.addr  = map_addr(aluoutM);
        new_req.wstrb = (|writeEnM) ? writeEnM : '0;
        new_req.wdata = writedata_decodedM;
    end

    // Next-state, bus drive and load-data capture
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        discard_d  = discard_q;
        readdata_d = readdata_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        bus_cur    = '0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    req_c     = 1'b1;
                    stall_c   = 1'b1;
                    bus_cur   = new_req;
                    req_d     = new_req;
                    discard_d = 1'b0;
                    state_d   = data_addr_ok ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // request cannot be withdrawn; a flush only marks it for discard
                req_c   = 1'b1;
                stall_c = 1'b1;
                bus_cur = req_q;
                if (flush_except)
                    discard_d = 1'b1;
                if (data_addr_ok) begin
                    state_d   = (discard_q | flush_except) ? S_CANCEL : S_WAIT;
                    discard_d = 1'b0;
                end
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (data_data_ok) begin
                    if (flush_except) begin
                        state_d = S_IDLE;
                    end else begin
                        if (!req_q.wr)
                            readdata_d = data_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush_except) begin
                    state_d = S_CANCEL;
                end
            end
            S_HOLD: begin
                // wait for other stall sources so the same access is not reissued
                if (!stallM)
                    state_d = S_IDLE;
            end
            S_CANCEL: begin
                stall_c = acc;
                if (data_data_ok)
                    state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            req_q      <= '0;
            discard_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            readdata_q <= readdata_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted
    always_comb begin
        data_req          = req_c & rst;
        stallreq_from_mem = stall_c & rst;
        data_wr           = bus_cur.wr & rst;
        data_size         = rst ? bus_cur.size  : 2'b00;
        data_addr         = rst ? bus_cur.addr  : '0;
        data_wstrb        = rst ? bus_cur.wstrb : '0;
        data_wdata        = rst ? bus_cur.wdata : '0;
        readdataM         = readdata_q;
    end

`ifdef DSRAM_BRIDGE_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_acc_q, perf_acc_d;

    // Saturating counters: stall cycles and completed accesses
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_acc_d   = perf_acc_q;
        if (stallreq_from_mem && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if ((state_q == S_WAIT) && data_data_ok && (perf_acc_q != 32'hFFFF_FFFF))
            perf_acc_d = perf_acc_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'd0;
            perf_acc_q   <= 32'd0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_acc_q   <= perf_acc_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_accesses     = perf_acc_q;
`endif

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: the bench plays the SRAM slave and
// the hazard unit (stallM = stallreq_from_mem | extra_stall).
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  readEnM = '0;
    logic [3:0]  writeEnM = '0;
    logic [31:0] aluoutM = '0;
    logic [31:0] writedata_decodedM = '0;
    logic [1:0]  size = '0;
    logic [31:0] exceptTypeM = '0;
    logic        flush_except = 1'b0;
    logic        stallM;
    logic        extra_stall = 1'b0;
    logic [31:0] readdataM;
    logic        stallreq_from_mem;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        data_data_ok = 1'b0;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    int req_cycles = 0;
    int s0;

    assign stallM = stallreq_from_mem | extra_stall;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .KSEG_MAP(1)) dut (
        .clk(clk), .rst(rst),
        .readEnM(readEnM), .writeEnM(writeEnM), .aluoutM(aluoutM),
        .writedata_decodedM(writedata_decodedM), .size(size),
        .exceptTypeM(exceptTypeM), .flush_except(flush_except), .stallM(stallM),
        .readdataM(readdataM), .stallreq_from_mem(stallreq_from_mem),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
        .data_data_ok(data_data_ok)
    );

    always @(posedge clk) begin
        if (stallreq_from_mem) stall_cycles <= stall_cycles + 1;
        if (data_req)          req_cycles   <= req_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        readEnM = '0; writeEnM = '0; aluoutM = '0; writedata_decodedM = '0;
        size = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; flush_except = 1'b0;
        exceptTypeM = '0;
    endtask

    initial begin
        // reset with a load presented: outputs must stay low
        #1 rst = 1'b0;
        readEnM = 4'hF; aluoutM = 32'h8000_1000; size = 2'd2;
        #2;
        chk("rst_readdata", readdataM, 32'h0);
        chk("rst_stall", {31'b0, stallreq_from_mem}, 32'h0);
        chk("rst_req", {31'b0, data_req}, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        idle_inputs();
        #10 rst = 1'b1;
        step();

        // LW kseg0, addr_ok in issue cycle, data_ok three cycles later
        s0 = stall_cycles;
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h8000_1000; data_addr_ok = 1'b1;
        #1;
        chk("lw_req", {31'b0, data_req}, 32'h1);
        chk("lw_addr", data_addr, 32'h0000_1000);
        chk("lw_wr", {31'b0, data_wr}, 32'h0);
        chk("lw_wstrb", {28'b0, data_wstrb}, 32'h0);
        chk("lw_size", {30'b0, data_size}, 32'h2);
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("lw_req_drop", {31'b0, data_req}, 32'h0);
        chk("lw_stall_w1", {31'b0, stallreq_from_mem}, 32'h1);
        step();
        step();
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        step();
        data_data_ok = 1'b0;
        #1;
        chk("lw_readdata", readdataM, 32'hDEAD_BEEF);
        chk("lw_hold_stall", {31'b0, stallreq_from_mem}, 32'h0);
        idle_inputs();
        step();
        chk("lw_stall_count", stall_cycles - s0, 32'd4);

        // stray data_ok in IDLE must be ignored
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        step();
        data_data_ok = 1'b0;
        chk("stray_dok", readdataM, 32'hDEAD_BEEF);

        // SB to kuseg (no mapping)
        writeEnM = 4'b0100; writedata_decodedM = 32'h00AB_0000; size = 2'd0;
        aluoutM = 32'h0000_2002; data_addr_ok = 1'b1;
        #1;
        chk("sb_wr", {31'b0, data_wr}, 32'h1);
        chk("sb_wstrb", {28'b0, data_wstrb}, 32'h4);
        chk("sb_size", {30'b0, data_size}, 32'h0);
        chk("sb_wdata", data_wdata, 32'h00AB_0000);
        chk("sb_addr", data_addr, 32'h0000_2002);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        step();
        data_data_ok = 1'b0;
        chk("sb_readdata", readdataM, 32'hDEAD_BEEF);
        chk("sb_hold_stall", {31'b0, stallreq_from_mem}, 32'h0);
        idle_inputs();
        step();

        // SW kseg1, addr_ok delayed while the M inputs wander
        writeEnM = 4'hF; writedata_decodedM = 32'h1122_3344; size = 2'd2;
        aluoutM = 32'hA000_4000;
        #1;
        chk("sw_issue_addr", data_addr, 32'h0000_4000);
        step();
        for (int i = 0; i < 5; i++) begin
            aluoutM = 32'h9000_0000 + 32'(i * 4);
            writedata_decodedM = 32'hFFFF_0000 | 32'(i);
            writeEnM = 4'b0001;
            data_addr_ok = (i == 4);
            #1;
            chk("req_addr_stable", data_addr, 32'h0000_4000);
            chk("req_wdata_stable", data_wdata, 32'h1122_3344);
            chk("req_wstrb_stable", {28'b0, data_wstrb}, 32'hF);
            chk("req_held", {31'b0, data_req}, 32'h1);
            step();
        end
        idle_inputs();
        writeEnM = 4'hF;
        #1;
        chk("sw_wait_noreq", {31'b0, data_req}, 32'h0);
        data_data_ok = 1'b1;
        step();
        idle_inputs();
        step();

        // flush in WAIT, new load presented next cycle
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h8000_0100; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; flush_except = 1'b1;
        #1;
        chk("fl_wait_stall", {31'b0, stallreq_from_mem}, 32'h1);
        step();
        flush_except = 1'b0; aluoutM = 32'h8000_0200;
        #1;
        chk("cancel_noreq", {31'b0, data_req}, 32'h0);
        chk("cancel_stall", {31'b0, stallreq_from_mem}, 32'h1);
        step();
        data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
        #1;
        chk("cancel_dok_noreq", {31'b0, data_req}, 32'h0);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("cancel_dropped", readdataM, 32'hDEAD_BEEF);
        chk("new_req", {31'b0, data_req}, 32'h1);
        chk("new_addr", data_addr, 32'h0000_0200);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        step();
        data_data_ok = 1'b0;
        chk("new_readdata", readdataM, 32'hCAFE_F00D);
        idle_inputs();
        step();

        // excepting instruction is not issued
        readEnM = 4'hF; aluoutM = 32'h0000_0040; exceptTypeM = 32'h1;
        #1;
        chk("exc_noreq", {31'b0, data_req}, 32'h0);
        chk("exc_nostall", {31'b0, stallreq_from_mem}, 32'h0);
        idle_inputs();
        step();

        // data_ok coinciding with addr_ok is ignored
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h0000_0080;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #1;
        chk("same_dok_stall", {31'b0, stallreq_from_mem}, 32'h1);
        chk("same_dok_data", readdataM, 32'hCAFE_F00D);
        data_data_ok = 1'b1; data_rdata = 32'h6666_6666;
        step();
        data_data_ok = 1'b0;
        chk("same_dok_later", readdataM, 32'h6666_6666);
        idle_inputs();
        step();

        // extra stall in HOLD: no reissue, one request cycle
        s0 = req_cycles;
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h0000_0300;
        data_addr_ok = 1'b1; extra_stall = 1'b1;
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0F0F_0F0F;
        step();
        data_data_ok = 1'b0;
        #1;
        chk("hold_noreq1", {31'b0, data_req}, 32'h0);
        chk("hold_nostall", {31'b0, stallreq_from_mem}, 32'h0);
        chk("hold_data", readdataM, 32'h0F0F_0F0F);
        step();
        chk("hold_noreq2", {31'b0, data_req}, 32'h0);
        step();
        chk("hold_noreq3", {31'b0, data_req}, 32'h0);
        extra_stall = 1'b0;
        step();
        idle_inputs();
        step();
        chk("single_req", req_cycles - s0, 32'd1);

        // reset in the middle of WAIT
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h8000_0400; data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstw_stall", {31'b0, stallreq_from_mem}, 32'h0);
        chk("rstw_req", {31'b0, data_req}, 32'h0);
        chk("rstw_data", readdataM, 32'h0);
        idle_inputs();
        data_data_ok = 1'b1; data_rdata = 32'hAAAA_AAAA;
        #3 rst = 1'b1;
        step();
        data_data_ok = 1'b0;
        chk("rstw_late_dok", readdataM, 32'h0);
        chk("rstw_idle", {31'b0, stallreq_from_mem}, 32'h0);
        readEnM = 4'hF; size = 2'd2; aluoutM = 32'h8000_0500; data_addr_ok = 1'b1;
        #1;
        chk("post_rst_req", {31'b0, data_req}, 32'h1);
        chk("post_rst_addr", data_addr, 32'h0000_0500);
        step();
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
        step();
        data_data_ok = 1'b0;
        chk("post_rst_data", readdataM, 32'h0BAD_F00D);
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
